// File: rtl/mp64_rom_arb.sv
// Two-port round-robin arbiter in front of a pipelined synchronous ROM, with bounded burst lock.
// Optional per-port stall counters are enabled by defining MP64_ROM_ARB_STATS_EN.
module mp64_rom_arb #(
    parameter int unsigned ADDR_W   = 12,
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned MAX_LOCK = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              a_req,
    input  logic              a_lock,
    input  logic [ADDR_W-1:0] a_addr,
    output logic              a_gnt,
    output logic              a_rvalid,
    output logic [DATA_W-1:0] a_rdata,
    input  logic              b_req,
    input  logic              b_lock,
    input  logic [ADDR_W-1:0] b_addr,
    output logic              b_gnt,
    output logic              b_rvalid,
    output logic [DATA_W-1:0] b_rdata,
`ifdef MP64_ROM_ARB_STATS_EN
    output logic [15:0]       a_stall_cnt,
    output logic [15:0]       b_stall_cnt,
`endif
    output logic              rom_ce,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_rdata
);

    localparam int unsigned CntW = $clog2(MAX_LOCK + 1);
    localparam logic [CntW-1:0] MaxCnt = CntW'(MAX_LOCK);

    typedef enum logic [1:0] {StArb, StLockA, StLockB} state_e;
    typedef enum logic {PortA = 1'b0, PortB = 1'b1} port_e;

    state_e          state_q, state_d;
    port_e           last_q, own_q, rr_last;
    logic [CntW-1:0] lock_cnt_q, lock_cnt_d;
    logic            vld_q;
    logic            hold_a, hold_b;

    always_comb begin
        a_gnt      = 1'b0;
        b_gnt      = 1'b0;
        hold_a     = 1'b0;
        hold_b     = 1'b0;
        rr_last    = last_q;
        state_d    = state_q;
        lock_cnt_d = lock_cnt_q;
        unique case (state_q)
            StLockA: begin
                hold_a  = a_req & a_lock & ~(b_req & (lock_cnt_q == MaxCnt));
                rr_last = PortA;
            end
            StLockB: begin
                hold_b  = b_req & b_lock & ~(a_req & (lock_cnt_q == MaxCnt));
                rr_last = PortB;
            end
            default: ;
        endcase

        if (hold_a || hold_b) begin
            a_gnt      = hold_a;
            b_gnt      = hold_b;
            lock_cnt_d = (lock_cnt_q == MaxCnt) ? MaxCnt : lock_cnt_q + CntW'(1);
        end else begin
            // Leaving a lock reuses the same cycle for a round-robin grant.
            if (a_req && b_req) begin
                a_gnt = (rr_last == PortB);
                b_gnt = (rr_last == PortA);
            end else begin
                a_gnt = a_req;
                b_gnt = b_req;
            end
            if (a_gnt && a_lock) begin
                state_d    = StLockA;
                lock_cnt_d = CntW'(1);
            end else if (b_gnt && b_lock) begin
                state_d    = StLockB;
                lock_cnt_d = CntW'(1);
            end else begin
                state_d    = StArb;
                lock_cnt_d = '0;
            end
        end

        if (!rst_n) begin
            a_gnt = 1'b0;
            b_gnt = 1'b0;
        end
    end

    assign rom_ce   = a_gnt | b_gnt;
    assign rom_addr = b_gnt ? b_addr : a_addr;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= StArb;
            last_q     <= PortB;
            lock_cnt_q <= '0;
            vld_q      <= 1'b0;
            own_q      <= PortA;
        end else begin
            state_q    <= state_d;
            lock_cnt_q <= lock_cnt_d;
            vld_q      <= rom_ce;
            if (rom_ce) begin
                last_q <= b_gnt ? PortB : PortA;
                own_q  <= b_gnt ? PortB : PortA;
            end
        end
    end

    // Gated by rst_n so a response landing during reset is dropped.
    assign a_rvalid = rst_n & vld_q & (own_q == PortA);
    assign b_rvalid = rst_n & vld_q & (own_q == PortB);
    assign a_rdata  = rom_rdata;
    assign b_rdata  = rom_rdata;

`ifdef MP64_ROM_ARB_STATS_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_stall_cnt <= '0;
            b_stall_cnt <= '0;
        end else begin
            if (a_req && !a_gnt && (a_stall_cnt != 16'hFFFF)) begin
                a_stall_cnt <= a_stall_cnt + 16'd1;
            end
            if (b_req && !b_gnt && (b_stall_cnt != 16'hFFFF)) begin
                b_stall_cnt <= b_stall_cnt + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_mp64_rom_arb.sv
// Self-checking bench for mp64_rom_arb: vector table, lock sequences and random traffic vs a model.
module tb_mp64_rom_arb;

    localparam int MaxLock = 8;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        a_req, a_lock, b_req, b_lock;
    logic [11:0] a_addr, b_addr;
    logic        a_gnt, b_gnt, a_rvalid, b_rvalid;
    logic [31:0] a_rdata, b_rdata;
    logic        rom_ce;
    logic [11:0] rom_addr;
    logic [31:0] rom_rdata;
`ifdef MP64_ROM_ARB_STATS_EN
    logic [15:0] a_stall_cnt, b_stall_cnt;
`endif

    mp64_rom_arb #(.ADDR_W(12), .DATA_W(32), .MAX_LOCK(MaxLock)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .a_req    (a_req),
        .a_lock   (a_lock),
        .a_addr   (a_addr),
        .a_gnt    (a_gnt),
        .a_rvalid (a_rvalid),
        .a_rdata  (a_rdata),
        .b_req    (b_req),
        .b_lock   (b_lock),
        .b_addr   (b_addr),
        .b_gnt    (b_gnt),
        .b_rvalid (b_rvalid),
        .b_rdata  (b_rdata),
`ifdef MP64_ROM_ARB_STATS_EN
        .a_stall_cnt (a_stall_cnt),
        .b_stall_cnt (b_stall_cnt),
`endif
        .rom_ce   (rom_ce),
        .rom_addr (rom_addr),
        .rom_rdata(rom_rdata)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] rom_val(input logic [11:0] a);
        if (a == 12'd0) return 32'hDEADBEEF;
        if (a == 12'd1) return 32'hCAFEBABE;
        return {4'h5, a, ~a, 4'hA};
    endfunction

    always_ff @(posedge clk) begin
        if (rom_ce) rom_rdata <= rom_val(rom_addr);
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: who holds a lock, how many locked grants in a row, last winner,
    // and the one read in flight. Ports: 0 none, 1 A, 2 B.
    int          m_lock = 0, m_run = 0, m_last = 2, m_pend = 0;
    logic [11:0] m_pend_addr = '0;
    int          m_astall = 0, m_bstall = 0;

    logic        obs_ag, obs_bg, obs_arv, obs_brv;
    logic [31:0] obs_ard, obs_brd;
    logic [15:0] obs_bstall;

    task automatic tick(input logic rst, input logic ar, input logic al, input logic [11:0] aa,
                        input logic br, input logic bl, input logic [11:0] ba);
        int  w;
        int  last;
        bit  keep;
        rst_n = rst; a_req = ar; a_lock = al; a_addr = aa;
        b_req = br; b_lock = bl; b_addr = ba;
        @(negedge clk);
        keep = 0;
        w    = 0;
        if (rst) begin
            if (m_lock == 1) keep = ar && al && !(br && m_run == MaxLock);
            if (m_lock == 2) keep = br && bl && !(ar && m_run == MaxLock);
            if (keep) begin
                w = m_lock;
            end else begin
                last = (m_lock != 0) ? m_lock : m_last;
                if (ar && br) w = (last == 1) ? 2 : 1;
                else if (ar) w = 1;
                else if (br) w = 2;
            end
        end
        obs_ag = a_gnt; obs_bg = b_gnt; obs_arv = a_rvalid; obs_brv = b_rvalid;
        obs_ard = a_rdata; obs_brd = b_rdata;
        chk("a_gnt", {31'd0, a_gnt}, {31'd0, w == 1});
        chk("b_gnt", {31'd0, b_gnt}, {31'd0, w == 2});
        chk("rom_ce", {31'd0, rom_ce}, {31'd0, w != 0});
        if (w != 0) chk("rom_addr", {20'd0, rom_addr}, {20'd0, (w == 2) ? ba : aa});
        chk("a_rvalid", {31'd0, a_rvalid}, {31'd0, rst && m_pend == 1});
        chk("b_rvalid", {31'd0, b_rvalid}, {31'd0, rst && m_pend == 2});
        if (rst && m_pend == 1) chk("a_rdata", a_rdata, rom_val(m_pend_addr));
        if (rst && m_pend == 2) chk("b_rdata", b_rdata, rom_val(m_pend_addr));
`ifdef MP64_ROM_ARB_STATS_EN
        obs_bstall = b_stall_cnt;
        chk("a_stall_cnt", {16'd0, a_stall_cnt}, m_astall);
        chk("b_stall_cnt", {16'd0, b_stall_cnt}, m_bstall);
`else
        obs_bstall = '0;
`endif
        @(posedge clk);
        #1;
        if (!rst) begin
            m_lock = 0; m_run = 0; m_last = 2; m_pend = 0;
            m_astall = 0; m_bstall = 0;
        end else begin
            if (ar && w != 1 && m_astall < 16'hFFFF) m_astall++;
            if (br && w != 2 && m_bstall < 16'hFFFF) m_bstall++;
            m_pend      = w;
            m_pend_addr = (w == 2) ? ba : aa;
            if (w != 0) m_last = w;
            if (keep) begin
                m_run = (m_run < MaxLock) ? m_run + 1 : MaxLock;
            end else if (w == 1 && al) begin
                m_lock = 1; m_run = 1;
            end else if (w == 2 && bl) begin
                m_lock = 2; m_run = 1;
            end else begin
                m_lock = 0; m_run = 0;
            end
        end
    endtask

    typedef struct packed {
        logic        rst;
        logic        ar, al;
        logic [11:0] aa;
        logic        br, bl;
        logic [11:0] ba;
        logic        eag, ebg, earv, ebrv;
        logic [31:0] edata;
    } vec_t;

    vec_t vt[13];

    initial begin
        //            rst  ar al aa  br bl ba   ag bg arv brv data
        vt[0]  = '{1'b0, 1'b1, 1'b0, 12'd0, 1'b1, 1'b0, 12'd1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0};
        vt[1]  = '{1'b1, 1'b1, 1'b0, 12'd0, 1'b0, 1'b0, 12'd1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0};
        vt[2]  = '{1'b1, 1'b0, 1'b0, 12'd0, 1'b0, 1'b0, 12'd1, 1'b0, 1'b0, 1'b1, 1'b0, 32'hDEADBEEF};
        vt[3]  = '{1'b0, 1'b0, 1'b0, 12'd0, 1'b0, 1'b0, 12'd1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0};
        vt[4]  = '{1'b1, 1'b1, 1'b0, 12'd0, 1'b1, 1'b0, 12'd1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0};
        vt[5]  = '{1'b1, 1'b1, 1'b0, 12'd0, 1'b1, 1'b0, 12'd1, 1'b0, 1'b1, 1'b1, 1'b0, 32'hDEADBEEF};
        vt[6]  = '{1'b1, 1'b1, 1'b0, 12'd0, 1'b1, 1'b0, 12'd1, 1'b1, 1'b0, 1'b0, 1'b1, 32'hCAFEBABE};
        vt[7]  = '{1'b1, 1'b1, 1'b0, 12'd0, 1'b1, 1'b0, 12'd1, 1'b0, 1'b1, 1'b1, 1'b0, 32'hDEADBEEF};
        vt[8]  = '{1'b1, 1'b0, 1'b0, 12'd0, 1'b0, 1'b0, 12'd1, 1'b0, 1'b0, 1'b0, 1'b1, 32'hCAFEBABE};
        vt[9]  = '{1'b1, 1'b1, 1'b0, 12'd0, 1'b0, 1'b0, 12'd1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0};
        // Reset lands on the response cycle of vt[9]: its rvalid must be dropped.
        vt[10] = '{1'b0, 1'b0, 1'b0, 12'd0, 1'b0, 1'b0, 12'd1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0};
        vt[11] = '{1'b1, 1'b1, 1'b0, 12'd0, 1'b1, 1'b0, 12'd1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0};
        vt[12] = '{1'b1, 1'b0, 1'b0, 12'd0, 1'b0, 1'b0, 12'd1, 1'b0, 1'b0, 1'b1, 1'b0, 32'hDEADBEEF};

        rst_n = 1'b0; a_req = 1'b0; a_lock = 1'b0; a_addr = '0;
        b_req = 1'b0; b_lock = 1'b0; b_addr = '0;
        @(posedge clk);
        #1;
        tick(1'b0, 1'b0, 1'b0, 12'd0, 1'b0, 1'b0, 12'd0);

        for (int i = 0; i < 13; i++) begin
            tick(vt[i].rst, vt[i].ar, vt[i].al, vt[i].aa, vt[i].br, vt[i].bl, vt[i].ba);
            chk($sformatf("vec%0d a_gnt", i), {31'd0, obs_ag}, {31'd0, vt[i].eag});
            chk($sformatf("vec%0d b_gnt", i), {31'd0, obs_bg}, {31'd0, vt[i].ebg});
            chk($sformatf("vec%0d a_rvalid", i), {31'd0, obs_arv}, {31'd0, vt[i].earv});
            chk($sformatf("vec%0d b_rvalid", i), {31'd0, obs_brv}, {31'd0, vt[i].ebrv});
            if (vt[i].earv) chk($sformatf("vec%0d a_rdata", i), obs_ard, vt[i].edata);
            if (vt[i].ebrv) chk($sformatf("vec%0d b_rdata", i), obs_brd, vt[i].edata);
        end

        // A locked against a waiting B: 8 A grants, one B, then A relocks for 8 more.
        tick(1'b0, 1'b0, 1'b0, 12'd0, 1'b0, 1'b0, 12'd0);
        for (int i = 0; i < 2 * MaxLock + 1; i++) begin
            tick(1'b1, 1'b1, 1'b1, 12'(i), 1'b1, 1'b0, 12'd1);
            chk($sformatf("lockrr%0d a_gnt", i), {31'd0, obs_ag}, {31'd0, i != MaxLock});
            chk($sformatf("lockrr%0d b_gnt", i), {31'd0, obs_bg}, {31'd0, i == MaxLock});
        end

        // Uncontested lock runs 20 cycles; B then wins immediately (count saturated).
        tick(1'b0, 1'b0, 1'b0, 12'd0, 1'b0, 1'b0, 12'd0);
        for (int i = 0; i < 20; i++) begin
            tick(1'b1, 1'b1, 1'b1, 12'd5, 1'b0, 1'b0, 12'd1);
            chk($sformatf("lone%0d a_gnt", i), {31'd0, obs_ag}, 32'd1);
        end
        tick(1'b1, 1'b1, 1'b1, 12'd5, 1'b1, 1'b0, 12'd1);
        chk("lone_release b_gnt", {31'd0, obs_bg}, 32'd1);
        chk("lone_release a_gnt", {31'd0, obs_ag}, 32'd0);

`ifdef MP64_ROM_ARB_STATS_EN
        tick(1'b0, 1'b0, 1'b0, 12'd0, 1'b0, 1'b0, 12'd0);
        tick(1'b1, 1'b1, 1'b1, 12'd2, 1'b0, 1'b0, 12'd3);
        for (int i = 0; i < 5; i++) tick(1'b1, 1'b1, 1'b1, 12'd2, 1'b1, 1'b0, 12'd3);
        tick(1'b1, 1'b0, 1'b0, 12'd0, 1'b0, 1'b0, 12'd0);
        chk("b_stall_cnt after 5 stalls", {16'd0, obs_bstall}, 32'd5);
`endif

        // Random traffic with occasional resets, checked against the model every cycle.
        for (int i = 0; i < 3000; i++) begin
            tick(($urandom_range(0, 99) != 0),
                 ($urandom_range(0, 3) != 0), $urandom_range(0, 1) == 1,
                 12'($urandom_range(0, 4095)),
                 ($urandom_range(0, 3) != 0), $urandom_range(0, 1) == 1,
                 12'($urandom_range(0, 4095)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mp64_rom_arb.md
Name: mp64_rom_arb

Overview:
- Two-requester arbiter that shares one pipelined synchronous ROM (mp64_rom: ce/addr in, rdata valid one cycle after the sampling edge).
- Port A is the instruction-fetch side; port B is the data/boot-loader side.
- Round-robin on conflicts, with optional per-port burst lock bounded against starvation.
- Routes each ROM response back to its owner with a 1-cycle valid strobe.

Parameters:
- ADDR_W, 12, ROM word-address width
- DATA_W, 32, ROM data width
- MAX_LOCK, 8, max consecutive locked grants while the other port waits (>=1)

Ports:
- clk  in  1  clock; all state updates on posedge
- rst_n  in  1  synchronous active-low reset
- a_req  in  1  port A read request (level, held until a_gnt)
- a_lock  in  1  port A requests burst lock
- a_addr  in  ADDR_W  port A word address
- a_gnt  out  1  port A request accepted this cycle (combinational)
- a_rvalid  out  1  port A read data valid
- a_rdata  out  DATA_W  port A read data
- b_req, b_lock, b_addr, b_gnt, b_rvalid, b_rdata  same as port A, for port B
- rom_ce  out  1  ROM chip enable
- rom_addr  out  ADDR_W  ROM address
- rom_rdata  in  DATA_W  ROM read data

Behaviour:
- Reset: the clock is clk; reset is synchronous and active-low on rst_n.
- While rst_n=0, force a_gnt=b_gnt=rom_ce=0.
- Reset values: state=ARB, last_q=B (so A wins the first tie), lock_cnt=0, vld_q=0, own_q=A, a_rvalid=b_rvalid=0.
- No-hold rule: a ROM read returning in the first cycle after reset release never produces an rvalid, even if it was issued before reset.
- Throughput: one grant per cycle, back-to-back.
- rom_ce = a_gnt|b_gnt.
- rom_addr = b_gnt ? b_addr : a_addr.
- Grant is combinational in cycle T. ROM samples at posedge end of T. Response is in cycle T+1: vld_q<=rom_ce, own_q<=winner; x_rvalid = vld_q & (own_q==x); x_rdata = rom_rdata (meaningful only with rvalid).
- At most one of a_gnt/b_gnt is high. A grant requires req.
- Round-robin (RR): only one port requesting → it wins. Both requesting → the port != last_q wins. last_q <= winner on every grant.
- States ARB, LOCK_A, LOCK_B.
- ARB:
  - apply RR.
  - If the winner has lock high, go to LOCK_winner with lock_cnt<=1.
  - Otherwise stay in ARB.
- LOCK_A:
  - Hold condition H = a_req & a_lock & ~(b_req & lock_cnt==MAX_LOCK).
  - If H: grant A, lock_cnt<=min(lock_cnt+1, MAX_LOCK), stay in LOCK_A.
  - If !H: apply RR in the same cycle with last_q treated as A, so B wins if requesting. Next state is LOCK_winner (cnt=1) if the winner's lock is high; otherwise ARB, cnt<=0.
  - The cycle where !H holds does not lose a slot: a grant is made whenever any req is high.
- LOCK_B: mirror of LOCK_A.
- While locked with no competing request, lock_cnt saturates at MAX_LOCK and the lock persists.
- Lock dropped while req is still high: behave as !H above.
- lock_cnt width = $clog2(MAX_LOCK+1).
- Address or lock changes on an ungranted request are allowed. Whatever is present in the grant cycle is used.

Optional Feature:
- MP64_ROM_ARB_STATS_EN defined: add outputs a_stall_cnt and b_stall_cnt, each 16 bits.
  - Each counter increments in every cycle its port has req=1 and gnt=0.
  - Counters saturate at 16'hFFFF.
  - Counters reset to 0 on rst_n=0.
- Macro undefined: these ports and registers do not exist. All other behaviour is identical.

Test Plan:
- ROM[0]=DEADBEEF, ROM[1]=CAFEBABE. a_req with a_addr=0 for one cycle → a_gnt=1 and rom_ce=1 that cycle; next cycle a_rvalid=1, a_rdata=DEADBEEF, b_rvalid=0.
- a_req and b_req held continuously, addrs 0 and 1, no lock → grants alternate A,B,A,B starting with A after reset. rvalids alternate one cycle later with DEADBEEF/CAFEBABE.
- a_req=a_lock=1 and b_req=1 continuously, MAX_LOCK=8 → A granted 8 consecutive cycles, then B granted once, then A relocks (A gets 8 more).
- A locked with b_req=0 for 20 cycles → 20 A grants. Raise b_req → B granted no later than the next cycle (cnt saturated at MAX_LOCK).
- Grant A in cycle T, assert rst_n=0 in T+1 → a_rvalid=0 in T+1. After release the state is ARB and a tie goes to A.
- Stats build: b_req held for 5 cycles while A holds a lock and cnt<MAX_LOCK → b_stall_cnt=5. Preload near saturation → stays at FFFF.
